// File: rtl/philv_pkg.sv
// Shared constants, trace FSM states and the trace entry layout.
// The per-entry timestamp field exists only when PHILV_TRACE_TIMESTAMP_EN is defined.
package philv_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int DEF_XLEN    = 32;
  localparam int TS_WIDTH    = 32;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [DEF_XLEN-1:0]    result;
`ifdef PHILV_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    cycle;
`endif
  } trace_entry_t;

  function automatic int entry_width(input int xlen);
`ifdef PHILV_TRACE_TIMESTAMP_EN
    return 2 * xlen + INSTR_WIDTH + TS_WIDTH;
`else
    return 2 * xlen + INSTR_WIDTH;
`endif
  endfunction

endpackage

// File: rtl/philv_trace_mem.sv
// Trace entry storage: one write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module philv_trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read data holds whenever no read is issued, which keeps readout stable under backpressure.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/philv_trace_buffer.sv
// Armed/triggered instruction trace capture with oldest-first readout.
// Optional per-entry cycle timestamp and rd_cycle port: define PHILV_TRACE_TIMESTAMP_EN.
module philv_trace_buffer
  import philv_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     cap_valid,
  input  logic [XLEN-1:0]          cap_pc,
  input  logic [INSTR_WIDTH-1:0]   cap_instr,
  input  logic [XLEN-1:0]          cap_result,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [INSTR_WIDTH-1:0]   rd_instr,
  output logic [XLEN-1:0]          rd_result,
`ifdef PHILV_TRACE_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]      rd_cycle,
`endif
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_width(XLEN);

  // Same field order as trace_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [XLEN-1:0]        result;
`ifdef PHILV_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    cycle;
`endif
  } entry_t;

  trace_state_e  r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_post_cnt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_left;
  logic          r_rd_valid;
`ifdef PHILV_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_cycle;
`endif

  logic          w_trig_now;
  logic          w_capture;
  logic          w_done;
  logic          w_rd_issue;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_post_nxt;
  entry_t        w_wr_entry;
  entry_t        w_rd_entry;
  logic [EW-1:0] w_rd_data;

  assign w_trig_now = (r_state == TR_ARMED) && trig;
  // With no post-trigger window the trigger cycle itself must not store anything.
  assign w_capture  = cap_valid &&
                      ((r_state == TR_POST) ||
                       ((r_state == TR_ARMED) && !(w_trig_now && (POST_TRIG == 0))));

  assign w_wr_ptr_nxt = w_capture ? r_wr_ptr + AW'(1) : r_wr_ptr;
  assign w_count_nxt  = (w_capture && (r_count != CW'(DEPTH))) ? r_count + CW'(1) : r_count;
  assign w_post_nxt   = (w_trig_now ? '0 : {1'b0, r_post_cnt}) + CW'(w_capture);
  assign w_done       = (w_trig_now || (r_state == TR_POST)) && (w_post_nxt == CW'(POST_TRIG));
  assign w_rd_issue   = (r_state == TR_DONE) && (r_rd_left != '0) && (!r_rd_valid || rd_ready);

  always_comb begin
    w_wr_entry        = '0;
    w_wr_entry.pc     = cap_pc;
    w_wr_entry.instr  = cap_instr;
    w_wr_entry.result = cap_result;
`ifdef PHILV_TRACE_TIMESTAMP_EN
    w_wr_entry.cycle  = r_cycle;
`endif
  end

  philv_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk       (clk),
    .rstb      (rstb),
    .i_wr_en   (w_capture),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= TR_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_rd_left  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_count  <= w_count_nxt;
      end
      case (r_state)
        TR_IDLE: begin
          if (arm) begin
            r_state    <= TR_ARMED;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
          end
        end
        TR_ARMED, TR_POST: begin
          if (w_trig_now || (r_state == TR_POST)) begin
            r_post_cnt <= w_post_nxt[AW-1:0];
            if (w_done) begin
              // Oldest entry sits count slots behind the write pointer.
              r_state   <= TR_DONE;
              r_rd_ptr  <= w_wr_ptr_nxt - w_count_nxt[AW-1:0];
              r_rd_left <= w_count_nxt;
            end else begin
              r_state <= TR_POST;
            end
          end
        end
        TR_DONE: begin
          if (w_rd_issue) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_rd_left  <= r_rd_left - CW'(1);
            r_rd_valid <= 1'b1;
          end else if (!r_rd_valid || rd_ready) begin
            r_rd_valid <= 1'b0;
            r_state    <= TR_IDLE;
          end
        end
        default: r_state <= TR_IDLE;
      endcase
    end
  end

`ifdef PHILV_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_cycle <= '0;
    else       r_cycle <= r_cycle + TS_WIDTH'(1);
  end
  assign rd_cycle = w_rd_entry.cycle;
`endif

  assign w_rd_entry = w_rd_data;
  assign rd_pc      = w_rd_entry.pc;
  assign rd_instr   = w_rd_entry.instr;
  assign rd_result  = w_rd_entry.result;
  assign rd_valid   = r_rd_valid;
  assign state      = r_state;
  assign count      = r_count;

endmodule

// File: doc/philv_trace_buffer.md
PHILV_TRACE_BUFFER -- requirements
Module: philv_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width of the PC and result fields.
REQ-002 SHALL have parameter DEPTH, default 16, the number of trace entries; it is a power of two and at least 4.
REQ-003 SHALL have parameter POST_TRIG, default 8, the number of entries captured from the trigger onward; it is in the range 0..DEPTH-1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rstb  in  1  reset; asynchronous assertion, active-low.
REQ-007 arm  in  1  pulse; starts a capture session when the state is IDLE.
REQ-008 trig  in  1  trigger event; acted on only in ARMED.
REQ-009 cap_valid  in  1  the core retired an instruction this cycle.
REQ-010 cap_pc  in  XLEN  PC of the retired instruction.
REQ-011 cap_instr  in  32  instruction word.
REQ-012 cap_result  in  XLEN  ALU output.
REQ-013 rd_valid  out  1  readout entry valid.
REQ-014 rd_ready  in  1  consumer accepts the readout entry.
REQ-015 rd_pc, rd_instr, rd_result  out  XLEN/32/XLEN  readout entry fields.
REQ-016 state  out  2  current state: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-017 count  out  clog2(DEPTH)+1  number of valid stored entries.

Function
REQ-018 In ARMED and POST, each cycle with cap_valid=1 SHALL write {pc,instr,result} at wr_ptr, wrap wr_ptr modulo DEPTH, and increment count, saturating at DEPTH (oldest entry overwritten).
REQ-019 Cycles with cap_valid=0 SHALL write nothing and SHALL NOT advance the post-trigger counter.
REQ-020 IDLE->ARMED on arm=1; entering ARMED SHALL clear wr_ptr and count.
REQ-021 ARMED->POST on trig=1; a capture in the trigger cycle SHALL count as post-trigger entry 1.
REQ-022 POST->DONE in the cycle the POST_TRIG-th post-trigger entry is written.
REQ-023 With POST_TRIG=0, trig SHALL cause ARMED->DONE with nothing written in that cycle.
REQ-024 In DONE, readout SHALL proceed oldest-first starting at (wr_ptr-count) mod DEPTH; rd_valid SHALL assert in the cycle after DONE is entered when count>0.
REQ-025 The readout handshake occurs when rd_valid and rd_ready are both 1; the next entry SHALL be presented on the following cycle, so throughput is 1 entry/cycle.
REQ-026 While rd_valid=1 and rd_ready=0, the rd_* outputs SHALL hold stable.
REQ-027 The cycle after the last handshake, or when DONE is entered with count=0, SHALL give state IDLE and rd_valid=0; count SHALL hold its captured value until the next arm.
REQ-028 arm outside IDLE and trig outside ARMED SHALL be ignored.

Reset
REQ-029 rstb=0 SHALL asynchronously force state=IDLE, wr_ptr=0, rd_ptr=0, count=0, the post-trigger counter to 0, rd_valid=0 and rd_* fields to 0; this holds mid-capture and mid-readout.
REQ-030 Entry storage SHALL NOT be reset.

Configuration
REQ-031 Macro PHILV_TRACE_TIMESTAMP_EN SHALL add a free-running 32-bit cycle counter (reset to 0), stored per entry and presented on an extra output rd_cycle[31:0].
REQ-032 Without PHILV_TRACE_TIMESTAMP_EN, the counter, the storage field and the rd_cycle port SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package philv_pkg SHALL hold INSTR_WIDTH=32, default XLEN, the trace state enum, and the trace entry struct (the timestamp field is guarded by the macro).
REQ-034 Storage SHALL be sub-module philv_trace_mem: one write port, one registered read port, DEPTH x entry width.

Verification (DEPTH=16, POST_TRIG=8)
REQ-035 Wrap: arm, then 20 captures with pc=0x00400000+4k, trig at k=11 -> DONE after k=18; count=16; readout pc 0x0040000C..0x00400048 in order.
REQ-036 Short: arm, trig with capture at k=3, 11 captures total -> count=11; readout pc 0x00400000..0x00400028; then state=IDLE.
REQ-037 Backpressure: hold rd_ready=0 for 5 cycles mid-readout -> rd_pc and rd_valid stable; no entry lost or duplicated.
REQ-038 Ignored events: trig in IDLE, arm in POST, and cap_valid=0 gaps -> no state change, no writes, and the post-trigger counter is unchanged.
REQ-039 Reset: rstb=0 in POST after 3 post-trigger captures -> state=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.
REQ-040 With PHILV_TRACE_TIMESTAMP_EN: captures at cycles 5 and 9 after reset -> rd_cycle reads 5 then 9.
